// File: rtl/rom_stream_pkg.sv
// Shared defaults, FSM encoding and a width helper for the ROM stream reader.
package rom_stream_pkg;

   localparam int ADDR_WIDTH_DEF  = 8;
   localparam int DATA_WIDTH_DEF  = 8;
   localparam int ROM_LATENCY_DEF = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Number of bits needed to hold any value in 0..max_val.
   function automatic int count_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/rom_stream_fifo.sv
// Small synchronous FIFO with first-word-fall-through head, flush and occupancy count.
module rom_stream_fifo
   import rom_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = 3,
   parameter int CNT_W      = count_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  head_valid,
   output logic [CNT_W-1:0]      count
);

   localparam int PTR_W = count_width(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  push_ok;
   logic                  pop_ok;

   // Pointers wrap explicitly because DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A push into a full buffer is only legal when the head leaves in the same cycle.
   assign pop_ok  = pop && (count != '0);
   assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);

   // Pointer and occupancy bookkeeping; flush empties the buffer in one edge.
   always_ff @(posedge clk) begin
      // NOTE: registers use <= so each one samples pre-edge values regardless of statement order.
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Word storage.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; the head is masked to zero while empty, so stale words never show.
      if (push_ok && !flush) mem[wr_ptr] <= push_data;
   end

   assign head_valid = (count != '0);
   assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rom_stream_reader.sv
// Sweeps a wrapping inclusive ROM address range and streams the words out as valid/ready,
// using credits so every word in flight through the ROM already owns a FIFO slot.
module rom_stream_reader
   import rom_stream_pkg::*;
#(
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int ROM_LATENCY = ROM_LATENCY_DEF,
   parameter int FIFO_DEPTH  = ROM_LATENCY + 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] first_addr,
   input  logic [ADDR_WIDTH-1:0] last_addr,
   output logic [ADDR_WIDTH-1:0] rom_address,
   input  logic [DATA_WIDTH-1:0] rom_q,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int CNT_W = count_width(FIFO_DEPTH);
   localparam int FLT_W = count_width(ROM_LATENCY + 1);
   localparam int SUM_W = count_width(FIFO_DEPTH + ROM_LATENCY + 2);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [ADDR_WIDTH-1:0] addr_inc;
   logic [ADDR_WIDTH-1:0] last_q, last_nxt;
   logic [ROM_LATENCY:0]  flight_sr, flight_nxt;  // bit k: word k edges past its issue
   logic [FLT_W-1:0]      in_flight;
   logic [CNT_W-1:0]      fifo_count;
   logic                  issue;
   logic                  flush;
   logic                  pop;
   logic                  credit_ok;
   logic                  pipe_empty;

   assign addr_inc   = rom_address + 1'b1;
   assign pop        = m_valid && m_ready;
   assign pipe_empty = (fifo_count == '0) && (flight_sr == '0);

   // A word popped this cycle frees its slot before the next issued word can land.
   assign credit_ok = (SUM_W'(in_flight) + SUM_W'(fifo_count)) < (SUM_W'(FIFO_DEPTH) + SUM_W'(pop));

   // Count of words issued to the ROM but not yet captured.
   always_comb begin
      in_flight = '0;
      for (int i = 0; i <= ROM_LATENCY; i++) in_flight = in_flight + FLT_W'(flight_sr[i]);
   end

   // Next-state, address issue and flush decisions; abort overrides everything else.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
      state_nxt = state;
      addr_nxt  = rom_address;
      last_nxt  = last_q;
      issue     = 1'b0;
      flush     = 1'b0;
      if (abort) begin
         flush     = 1'b1;
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  issue     = 1'b1;
                  addr_nxt  = first_addr;
                  last_nxt  = last_addr;
                  state_nxt = (first_addr == last_addr) ? DRAIN : RUN;
               end
            end
            RUN: begin
               if (credit_ok) begin
                  issue    = 1'b1;
                  addr_nxt = addr_inc;
                  if (addr_inc == last_q) state_nxt = DRAIN;
               end
            end
            DRAIN: begin
               if (pipe_empty) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign flight_nxt = flush ? '0 : {flight_sr[ROM_LATENCY-1:0], issue};

   // Sweep state, issued address, latched end address and in-flight tags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rom_address <= '0;
         last_q      <= '0;
         flight_sr   <= '0;
      end else begin
         state       <= state_nxt;
         rom_address <= addr_nxt;
         last_q      <= last_nxt;
         flight_sr   <= flight_nxt;
      end
   end

   rom_stream_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .push       (flight_sr[ROM_LATENCY]),
      .push_data  (rom_q),
      .pop        (pop),
      .head_data  (m_data),
      .head_valid (m_valid),
      .count      (fifo_count)
   );

   assign busy = (state != IDLE);
   assign done = (state == DRAIN) && pipe_empty && !abort;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader with a behavioural one-cycle ROM.
module tb_rom_stream_reader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       m_ready = 1'b0;
   logic [7:0] first_addr = '0;
   logic [7:0] last_addr = '0;
   logic [7:0] rom_q;
   logic [7:0] rom_address;
   logic [7:0] m_data;
   logic       m_valid;
   logic       busy;
   logic       done;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   bit         sb_flush = 1'b0;
   bit         exp_done = 1'b0;
   bit         hold_prev = 1'b0;
   logic [7:0] hold_data = '0;

   int         issued, xfer, max_out;
   bit         seen_done;
   logic [7:0] prev_addr;
   logic [15:0] ready_pat = 16'b1011_0110_1101_0011;

   always #5 clk = ~clk;

   rom_stream_reader dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .first_addr  (first_addr),
      .last_addr   (last_addr),
      .rom_address (rom_address),
      .rom_q       (rom_q),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .busy        (busy),
      .done        (done)
   );

   // Distinct contents per address so order errors are visible.
   function automatic logic [7:0] rom_fn(input logic [7:0] a);
      return (a * 8'd37) ^ 8'hC3;
   endfunction

   // single_port_rom stand-in: registered read, one edge of latency.
   always @(posedge clk) rom_q <= rom_fn(rom_address);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected words on each handshake, checks done and stall stability.
   always @(negedge clk) begin
      if (sb_flush || reset) begin
         exp_q.delete();
         exp_done  = 1'b0;
         hold_prev = 1'b0;
      end else begin
         if (exp_done) begin
            check("done_after_last", done, 1);
            exp_done = 1'b0;
         end else if (done) begin
            check("spurious_done", done, 0);
         end
         if (hold_prev) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, hold_data);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_word", exp_q.size(), 1);
            end else begin
               check("m_data", m_data, exp_q.pop_front());
               if (exp_q.size() == 0) exp_done = 1'b1;
            end
         end
         hold_prev = m_valid && !m_ready;
         hold_data = m_data;
      end
   end

   // Pulse start for one edge and queue the words the sweep must return.
   task automatic start_sweep(input logic [7:0] first, input logic [7:0] last);
      logic [7:0] d;
      d = last - first;
      for (int i = 0; i <= int'(d); i++) exp_q.push_back(rom_fn(8'(first + 8'(i))));
      first_addr = first;
      last_addr  = last;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Full-rate sweep with per-cycle address, valid, done and busy expectations.
   task automatic run_sweep(input logic [7:0] first, input logic [7:0] last);
      logic [7:0] d;
      logic [7:0] ea;
      int         n;
      d = last - first;
      n = int'(d) + 1;
      m_ready = 1'b1;
      start_sweep(first, last);
      for (int k = 0; k <= n + 3; k++) begin
         @(negedge clk);
         ea = first + 8'((k < n) ? k : n - 1);
         check("rom_address", rom_address, ea);
         check("m_valid", m_valid, (k >= 2) && (k <= n + 1));
         check("done", done, k == n + 2);
         check("busy", busy, k <= n + 2);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_rom_address", rom_address, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(posedge clk);
      #1;

      // Plain, wrapping and single-word sweeps at full rate.
      run_sweep(8'd0, 8'd50);
      run_sweep(8'd250, 8'd3);
      run_sweep(8'd7, 8'd7);

      // Backpressure with a 10-cycle stall: outstanding words must cap at the FIFO depth.
      start_sweep(8'd0, 8'd20);
      issued    = 1;
      xfer      = 0;
      max_out   = 0;
      seen_done = 1'b0;
      prev_addr = 8'd0;
      for (int c = 0; c < 300 && !seen_done; c++) begin
         m_ready = (c >= 3 && c < 13) ? 1'b0 : ready_pat[c % 16];
         @(negedge clk);
         if (rom_address != prev_addr) begin
            issued++;
            prev_addr = rom_address;
         end
         if (issued - xfer > max_out) max_out = issued - xfer;
         if (m_valid && m_ready) xfer++;
         if (done) seen_done = 1'b1;
         @(posedge clk);
         #1;
      end
      check("bp_done_seen", seen_done, 1);
      check("bp_max_outstanding", max_out, 3);
      check("bp_words", xfer, 21);
      check("bp_issued", issued, 21);

      // Abort on the fifth issued address with the consumer stalled.
      m_ready = 1'b1;
      start_sweep(8'd0, 8'd40);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      m_ready  = 1'b0;
      abort    = 1'b1;
      sb_flush = 1'b1;
      @(posedge clk);
      #1;
      abort    = 1'b0;
      sb_flush = 1'b0;
      @(negedge clk);
      check("abort_addr_held", rom_address, 4);
      check("abort_m_valid", m_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      repeat (5) @(negedge clk);
      check("abort_discard", m_valid, 0);
      @(posedge clk);
      #1;
      run_sweep(8'd10, 8'd12);

      // Start while busy is ignored; reset mid-sweep restores reset values.
      m_ready = 1'b1;
      start_sweep(8'd30, 8'd60);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      first_addr = 8'd100;
      last_addr  = 8'd100;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("busy_start_addr", rom_address, 35);
      check("busy_start_busy", busy, 1);
      @(posedge clk);
      #1;
      m_ready  = 1'b0;
      reset    = 1'b1;
      sb_flush = 1'b1;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      sb_flush = 1'b0;
      @(negedge clk);
      check("mid_rst_rom_address", rom_address, 0);
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_rst_m_data", m_data, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      @(posedge clk);
      #1;
      run_sweep(8'd5, 8'd6);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
